count_seq_gen: RTL and testbench

//  Upstream stimulus stage for the count/prevcount increment checker. Produces a WIDTH-bit

---
 rtl/count_seq_gen_pkg.sv | 10 +
 rtl/count_seq_gen_if.sv | 40 ++++
 rtl/count_seq_gen_sat_ctr.sv | 20 ++
 rtl/count_seq_gen.sv | 116 +++++++++++
 tb/tb_count_seq_gen.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/count_seq_gen_pkg.sv
// Shared types and defaults for the count/prevcount sequence generator.
// The optional error injector is enabled with COUNT_SEQ_ERR_INJECT_EN.
package count_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} count_seq_state_e;

    localparam int COUNT_SEQ_DEF_WIDTH      = 4;
    localparam int COUNT_SEQ_DEF_WRAP_CNT_W = 8;

endpackage

// File: rtl/count_seq_gen_if.sv
// Handshake and sequence bus between the generator (master) and its consumer (slave).
// COUNT_SEQ_ERR_INJECT_EN adds the inj_skip request line.
interface count_seq_gen_if
    import count_seq_pkg::*;
#(
    parameter int WIDTH      = COUNT_SEQ_DEF_WIDTH,
    parameter int WRAP_CNT_W = COUNT_SEQ_DEF_WRAP_CNT_W
);

    logic                  en;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  load_ack;
    logic                  ready;
    logic                  valid;
    logic [WIDTH-1:0]      count;
    logic [WIDTH-1:0]      prevcount;
    logic                  wrap;
    logic [WRAP_CNT_W-1:0] wrap_cnt;
`ifdef COUNT_SEQ_ERR_INJECT_EN
    logic                  inj_skip;
`endif

    modport master (
`ifdef COUNT_SEQ_ERR_INJECT_EN
        input  inj_skip,
`endif
        input  en, load, load_val, ready,
        output load_ack, valid, count, prevcount, wrap, wrap_cnt
    );

    modport slave (
`ifdef COUNT_SEQ_ERR_INJECT_EN
        output inj_skip,
`endif
        output en, load, load_val, ready,
        input  load_ack, valid, count, prevcount, wrap, wrap_cnt
    );

endinterface

// File: rtl/count_seq_gen_sat_ctr.sv
// Saturating up-counter used to tally accepted wrap beats.
module count_seq_sat_ctr #(
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [WRAP_CNT_W-1:0] value
);

    // Count up on each request and stick at all-ones instead of rolling over.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/count_seq_gen.sv
// Wrapping count/prevcount sequence source with valid/ready handshake, load and
// wrap tally. Defining COUNT_SEQ_ERR_INJECT_EN enables the +2 skip injector.
module count_seq_gen
    import count_seq_pkg::*;
#(
    parameter int               WIDTH      = COUNT_SEQ_DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT_COUNT = '0,
    parameter int               WRAP_CNT_W = COUNT_SEQ_DEF_WRAP_CNT_W
) (
    input logic                  clk,
    input logic                  rst,
    count_seq_gen_if.master      bus
);

    count_seq_state_e state;
    logic             valid_q;
    logic             wrap_q;
    logic             load_ack_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] prev_q;

    logic             slot_free;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] adv_count;
    logic             adv_carry;

    assign slot_free = !valid_q || bus.ready;

    // Next value on advance; the carry out marks a crossing through zero.
    always_comb begin
        step = (WIDTH+1)'(1);
`ifdef COUNT_SEQ_ERR_INJECT_EN
        if (bus.inj_skip) begin
            step = (WIDTH+1)'(2);
        end
`endif
        sum       = {1'b0, count_q} + step;
        adv_count = sum[WIDTH-1:0];
        adv_carry = sum[WIDTH];
    end

    // Control FSM with registered beat outputs; a load always beats an advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            load_ack_q <= 1'b0;
            count_q    <= INIT_COUNT;
            prev_q     <= WIDTH'(INIT_COUNT - 1'b1);
        end else begin
            load_ack_q <= 1'b0;
            if (bus.load && slot_free) begin
                count_q    <= bus.load_val;
                prev_q     <= WIDTH'(bus.load_val - 1'b1);
                wrap_q     <= 1'b0;
                load_ack_q <= 1'b1;
                valid_q    <= 1'b1;
                state      <= RUN;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.en) begin
                            valid_q <= 1'b1;
                            state   <= RUN;
                        end
                    end
                    RUN: begin
                        if (bus.ready) begin
                            if (bus.en) begin
                                prev_q  <= count_q;
                                count_q <= adv_count;
                                wrap_q  <= adv_carry;
                            end else begin
                                valid_q <= 1'b0;
                                wrap_q  <= 1'b0;
                                state   <= IDLE;
                            end
                        end else if (!bus.en) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (bus.ready) begin
                            valid_q <= 1'b0;
                            wrap_q  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        valid_q <= 1'b0;
                        wrap_q  <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

    count_seq_sat_ctr #(
        .WRAP_CNT_W(WRAP_CNT_W)
    ) u_wrap_ctr (
        .clk  (clk),
        .rst  (rst),
        .inc  (valid_q && bus.ready && wrap_q),
        .value(bus.wrap_cnt)
    );

    assign bus.valid     = valid_q;
    assign bus.count     = count_q;
    assign bus.prevcount = prev_q;
    assign bus.wrap      = wrap_q;
    assign bus.load_ack  = load_ack_q;

endmodule

// File: tb/tb_count_seq_gen.sv
// Directed, table-driven bench for count_seq_gen plus a saturation run on a
// second instance with a 2-bit wrap counter. Honours COUNT_SEQ_ERR_INJECT_EN.
module tb_count_seq_gen;
    import count_seq_pkg::*;

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [3:0] load_val;
        logic       ready;
        logic       inj;
        logic       exp_valid;
        logic [3:0] exp_count;
        logic [3:0] exp_prev;
        logic       exp_wrap;
        logic       exp_ack;
        logic [7:0] exp_wcnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic sat_rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    count_seq_gen_if #(.WIDTH(4), .WRAP_CNT_W(8)) bus ();
    count_seq_gen_if #(.WIDTH(4), .WRAP_CNT_W(2)) sat_bus ();

    count_seq_gen #(.WIDTH(4), .INIT_COUNT(4'h0), .WRAP_CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    count_seq_gen #(.WIDTH(4), .INIT_COUNT(4'h0), .WRAP_CNT_W(2)) dut_sat (
        .clk(clk),
        .rst(sat_rst),
        .bus(sat_bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic l, input logic [3:0] lv,
                                input logic rd, input logic inj, input logic ev, input logic [3:0] ec,
                                input logic [3:0] ep, input logic ew, input logic ea, input logic [7:0] ewc);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.load_val = lv; v.ready = rd; v.inj = inj;
        v.exp_valid = ev; v.exp_count = ec; v.exp_prev = ep; v.exp_wrap = ew;
        v.exp_ack = ea; v.exp_wcnt = ewc;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst          = v.rst;
        bus.en       = v.en;
        bus.load     = v.load;
        bus.load_val = v.load_val;
        bus.ready    = v.ready;
`ifdef COUNT_SEQ_ERR_INJECT_EN
        bus.inj_skip = v.inj;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic build_table();
        logic [3:0] sk_c1, sk_p1, sk_c2, sk_p2;
`ifdef COUNT_SEQ_ERR_INJECT_EN
        sk_c1 = 4'h5; sk_p1 = 4'h3; sk_c2 = 4'h6; sk_p2 = 4'h5;
`else
        sk_c1 = 4'h4; sk_p1 = 4'h3; sk_c2 = 4'h5; sk_p2 = 4'h4;
`endif
        // reset state
        vecs.push_back(mk(1,0,0,4'h0,0,0, 0,4'h0,4'hF,0,0,8'd0));
        vecs.push_back(mk(1,0,0,4'h0,0,0, 0,4'h0,4'hF,0,0,8'd0));
        // free run through the all-ones -> zero wrap
        for (int i = 0; i < 18; i++) begin
            vecs.push_back(mk(0,1,0,4'h0,1,0, 1,4'(i),4'(i-1),(i == 16),0,
                              (i == 17) ? 8'd1 : 8'd0));
        end
        vecs.push_back(mk(0,1,0,4'h0,1,0, 1,4'h2,4'h1,0,0,8'd1));
        vecs.push_back(mk(0,1,0,4'h0,1,0, 1,4'h3,4'h2,0,0,8'd1));
        vecs.push_back(mk(0,1,0,4'h0,1,0, 1,4'h4,4'h3,0,0,8'd1));
        vecs.push_back(mk(0,1,0,4'h0,1,0, 1,4'h5,4'h4,0,0,8'd1));
        // stall three cycles at (5,4)
        vecs.push_back(mk(0,1,0,4'h0,0,0, 1,4'h5,4'h4,0,0,8'd1));
        vecs.push_back(mk(0,1,0,4'h0,0,0, 1,4'h5,4'h4,0,0,8'd1));
        vecs.push_back(mk(0,1,0,4'h0,0,0, 1,4'h5,4'h4,0,0,8'd1));
        vecs.push_back(mk(0,1,0,4'h0,1,0, 1,4'h6,4'h5,0,0,8'd1));
        // load during a stall waits for ready
        vecs.push_back(mk(0,1,1,4'hA,0,0, 1,4'h6,4'h5,0,0,8'd1));
        vecs.push_back(mk(0,1,1,4'hA,0,0, 1,4'h6,4'h5,0,0,8'd1));
        vecs.push_back(mk(0,1,1,4'hA,1,0, 1,4'hA,4'h9,0,1,8'd1));
        vecs.push_back(mk(0,1,0,4'h0,1,0, 1,4'hB,4'hA,0,0,8'd1));
        // load of zero does not flag a wrap
        vecs.push_back(mk(0,1,1,4'h0,1,0, 1,4'h0,4'hF,0,1,8'd1));
        vecs.push_back(mk(0,1,0,4'h0,1,0, 1,4'h1,4'h0,0,0,8'd1));
        // drop en while stalled -> drain, then idle
        vecs.push_back(mk(0,0,0,4'h0,0,0, 1,4'h1,4'h0,0,0,8'd1));
        vecs.push_back(mk(0,0,0,4'h0,0,0, 1,4'h1,4'h0,0,0,8'd1));
        vecs.push_back(mk(0,0,0,4'h0,1,0, 0,4'h1,4'h0,0,0,8'd1));
        vecs.push_back(mk(0,0,0,4'h0,1,0, 0,4'h1,4'h0,0,0,8'd1));
        // restart from idle presents the held registers first
        vecs.push_back(mk(0,1,0,4'h0,1,0, 1,4'h1,4'h0,0,0,8'd1));
        vecs.push_back(mk(0,1,0,4'h0,1,0, 1,4'h2,4'h1,0,0,8'd1));
        vecs.push_back(mk(0,1,0,4'h0,1,0, 1,4'h3,4'h2,0,0,8'd1));
        // skip request at (3,2)
        vecs.push_back(mk(0,1,0,4'h0,1,1, 1,sk_c1,sk_p1,0,0,8'd1));
        vecs.push_back(mk(0,1,0,4'h0,1,0, 1,sk_c2,sk_p2,0,0,8'd1));
        // reset in RUN
        vecs.push_back(mk(1,1,0,4'h0,1,0, 0,4'h0,4'hF,0,0,8'd0));
        vecs.push_back(mk(0,0,0,4'h0,1,0, 0,4'h0,4'hF,0,0,8'd0));
    endtask

    initial begin
        int  budget;
        logic got_ack;

        rst              = 1'b1;
        bus.en           = 1'b0;
        bus.load         = 1'b0;
        bus.load_val     = 4'h0;
        bus.ready        = 1'b0;
        sat_rst          = 1'b1;
        sat_bus.en       = 1'b0;
        sat_bus.load     = 1'b0;
        sat_bus.load_val = 4'h0;
        sat_bus.ready    = 1'b0;
`ifdef COUNT_SEQ_ERR_INJECT_EN
        bus.inj_skip     = 1'b0;
        sat_bus.inj_skip = 1'b0;
`endif
        build_table();

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("step%0d valid", i), 32'(bus.valid), 32'(vecs[i].exp_valid));
            check_output($sformatf("step%0d count", i), 32'(bus.count), 32'(vecs[i].exp_count));
            check_output($sformatf("step%0d prevcount", i), 32'(bus.prevcount), 32'(vecs[i].exp_prev));
            check_output($sformatf("step%0d wrap", i), 32'(bus.wrap), 32'(vecs[i].exp_wrap));
            check_output($sformatf("step%0d load_ack", i), 32'(bus.load_ack), 32'(vecs[i].exp_ack));
            check_output($sformatf("step%0d wrap_cnt", i), 32'(bus.wrap_cnt), 32'(vecs[i].exp_wcnt));
        end

        // Load from IDLE with downstream stalled; wait a bounded time for the ack.
        bus.en       = 1'b0;
        bus.ready    = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 4'h7;
        got_ack      = 1'b0;
        budget       = 0;
        while (!got_ack && budget < 4) begin
            @(posedge clk);
            #1;
            budget++;
            if (bus.load_ack) got_ack = 1'b1;
        end
        bus.load = 1'b0;
        check_output("idle_load ack_seen", 32'(got_ack), 32'd1);
        check_output("idle_load ack_latency", 32'(budget), 32'd1);
        check_output("idle_load valid", 32'(bus.valid), 32'd1);
        check_output("idle_load count", 32'(bus.count), 32'h7);
        check_output("idle_load prevcount", 32'(bus.prevcount), 32'h6);
        @(posedge clk);
        #1;
        check_output("idle_load ack_pulse", 32'(bus.load_ack), 32'd0);
        check_output("idle_load held", 32'(bus.count), 32'h7);
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("idle_load to_idle", 32'(bus.valid), 32'd0);

        // Saturation of a 2-bit wrap counter over six wraps.
        check_output("sat reset", 32'(sat_bus.wrap_cnt), 32'd0);
        @(posedge clk);
        #1;
        sat_rst       = 1'b0;
        sat_bus.en    = 1'b1;
        sat_bus.ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_output("sat after_2_wraps", 32'(sat_bus.wrap_cnt), 32'd2);
        repeat (60) @(posedge clk);
        #1;
        check_output("sat saturated", 32'(sat_bus.wrap_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
